feature_reader: RTL and testbench

// - Read-side counterpart of the new-feature BRAM writer. Started after gat_ready.
// - Reads NUM_FEATURE_OUT words per node from port B of the feature BRAM.
// - Packs each node's words into one vector and streams vectors downstream (next GAT layer / host DMA) with valid/ready.
// - Nodes are emitted in order 0..NUM_SUBGRAPHS-1.

---
 rtl/feature_reader_if.sv | 33 +++
 rtl/feature_reader.sv | 144 ++++++++++++++
 tb/tb_feature_reader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_reader_if.sv
// Feature BRAM port-B read bus plus the packed node-vector stream of feature_reader.
// master = reader side, slave = BRAM model / downstream consumer side.
interface feature_reader_if #(
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int NUM_SUBGRAPHS     = 2708
);
    localparam int ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT);
    localparam int IDX_W  = $clog2(NUM_SUBGRAPHS);

    logic                                         feat_bram_enb;
    logic [ADDR_W-1:0]                            feat_bram_addrb;
    logic [NEW_FEATURE_WIDTH-1:0]                 feat_bram_doutb;
    logic                                         node_vld_o;
    logic                                         node_rdy_i;
    logic [NUM_FEATURE_OUT*NEW_FEATURE_WIDTH-1:0] node_feat_o;
    logic [IDX_W-1:0]                             node_idx_o;
    logic                                         node_last_o;

    modport master (
        output feat_bram_enb, feat_bram_addrb,
        input  feat_bram_doutb,
        output node_vld_o, node_feat_o, node_idx_o, node_last_o,
        input  node_rdy_i
    );

    modport slave (
        input  feat_bram_enb, feat_bram_addrb,
        output feat_bram_doutb,
        input  node_vld_o, node_feat_o, node_idx_o, node_last_o,
        output node_rdy_i
    );
endinterface

// File: rtl/feature_reader.sv
// Streams each node's NUM_FEATURE_OUT feature words from BRAM port B as one packed vector.
// Nodes go out in order 0..NUM_SUBGRAPHS-1, one node in flight at a time.
module feature_reader #(
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int NUM_SUBGRAPHS     = 2708,
    parameter int BRAM_RD_LAT       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    feature_reader_if.master bus,
    output logic             busy_o,
    output logic             done_o
);
    localparam int W      = NEW_FEATURE_WIDTH;
    localparam int DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IDX_W  = $clog2(NUM_SUBGRAPHS);
    localparam int K_W    = $clog2(NUM_FEATURE_OUT);
    localparam int KC_W   = K_W + 1;

    localparam logic [KC_W-1:0]   K_END    = KC_W'(NUM_FEATURE_OUT);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(NUM_FEATURE_OUT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SUBGRAPHS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, FILL, HOLD, DONE} state_t;

    state_t                           state;
    logic [KC_W-1:0]                  k;
    logic [K_W-1:0]                   rd_k;
    logic [ADDR_W-1:0]                base;
    logic [ADDR_W-1:0]                addrb;
    logic [IDX_W-1:0]                 node;
    logic                             enb;
    logic                             vld;
    logic                             last;
    logic                             done;
    logic                             pending;
    logic [BRAM_RD_LAT-1:0]           trk_vld_p;
    logic [K_W-1:0]                   trk_k_p [BRAM_RD_LAT];
    logic [NUM_FEATURE_OUT-1:0][W-1:0] pack;

    // A read still owes data after this edge if it is being issued now or sits ahead of the last tracker slot.
    always_comb begin
        pending = enb;
        for (int i = 0; i < BRAM_RD_LAT - 1; i++) pending = pending | trk_vld_p[i];
    end

    // In-flight tracker: slot 0 tags the read the BRAM samples this edge, the last slot owns doutb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_vld_p <= '0;
            for (int i = 0; i < BRAM_RD_LAT; i++) trk_k_p[i] <= '0;
            pack <= '0;
        end else begin
            trk_vld_p[0] <= enb;
            trk_k_p[0]   <= rd_k;
            for (int i = 1; i < BRAM_RD_LAT; i++) begin
                trk_vld_p[i] <= trk_vld_p[i-1];
                trk_k_p[i]   <= trk_k_p[i-1];
            end
            if (trk_vld_p[BRAM_RD_LAT-1]) pack[trk_k_p[BRAM_RD_LAT-1]] <= bus.feat_bram_doutb;
        end
    end

    // Control FSM; enb/addrb are registered one cycle ahead, so k holds the next word to request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            rd_k  <= '0;
            base  <= '0;
            addrb <= '0;
            node  <= '0;
            enb   <= 1'b0;
            vld   <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    base <= '0;
                    if (start_i) begin
                        state <= FETCH;
                        node  <= '0;
                        enb   <= 1'b1;
                        addrb <= '0;
                        rd_k  <= '0;
                        k     <= KC_W'(1);
                    end
                end
                FETCH: begin
                    if (k == K_END) begin
                        state <= FILL;
                        enb   <= 1'b0;
                        k     <= '0;
                    end else begin
                        addrb <= base + ADDR_W'(k);
                        rd_k  <= k[K_W-1:0];
                        k     <= k + 1'b1;
                    end
                end
                FILL: begin
                    if (!pending) begin
                        state <= HOLD;
                        vld   <= 1'b1;
                        last  <= (node == LAST_IDX);
                    end
                end
                HOLD: begin
                    if (bus.node_rdy_i) begin
                        vld  <= 1'b0;
                        last <= 1'b0;
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            node  <= node + 1'b1;
                            base  <= base + STRIDE;
                            enb   <= 1'b1;
                            addrb <= base + STRIDE;
                            rd_k  <= '0;
                            k     <= KC_W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.feat_bram_enb   = enb;
    assign bus.feat_bram_addrb = addrb;
    assign bus.node_vld_o      = vld;
    assign bus.node_feat_o     = pack;
    assign bus.node_idx_o      = node;
    assign bus.node_last_o     = last;
    assign busy_o              = (state != IDLE);
    assign done_o              = done;
endmodule

// File: tb/tb_feature_reader.sv
// Directed bench for feature_reader: 4 words/node, 3 nodes, read latency 2 (dut_a) and 1 (dut_b).
// BRAM models return 32'hA000_0000+addr and garbage when not enabled.
module tb_feature_reader;
  localparam int W  = 32;
  localparam int NF = 4;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic rdy_a = 1'b0, rdy_b = 1'b1;
  logic busy_a, done_a, busy_b, done_b;
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;

  typedef struct {
    logic [127:0] feat;
    int           idx;
    logic         last;
    int           cyc;
  } xf_t;

  xf_t xqa[$];
  xf_t xqb[$];
  int  rda[$];
  int  rdc[$];
  int  n_done_a = 0, n_done_b = 0, done_cyc_a = 0;
  logic [31:0] ra [2];
  logic [31:0] rb;
  logic [127:0] exp_n [NS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  feature_reader_if #(.NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(NF), .NUM_SUBGRAPHS(NS)) ifa ();
  feature_reader_if #(.NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(NF), .NUM_SUBGRAPHS(NS)) ifb ();

  feature_reader #(.NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(NF), .NUM_SUBGRAPHS(NS), .BRAM_RD_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .bus(ifa), .busy_o(busy_a), .done_o(done_a));
  feature_reader #(.NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(NF), .NUM_SUBGRAPHS(NS), .BRAM_RD_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .bus(ifb), .busy_o(busy_b), .done_o(done_b));

  // BRAM models: two-stage and one-stage read pipelines
  always @(posedge clk) begin
    ra[0] <= ifa.feat_bram_enb ? 32'hA000_0000 + 32'(ifa.feat_bram_addrb) : 32'hDEAD_BEEF;
    ra[1] <= ra[0];
    rb    <= ifb.feat_bram_enb ? 32'hA000_0000 + 32'(ifb.feat_bram_addrb) : 32'hDEAD_BEEF;
  end
  assign ifa.feat_bram_doutb = ra[1];
  assign ifb.feat_bram_doutb = rb;
  assign ifa.node_rdy_i      = rdy_a;
  assign ifb.node_rdy_i      = rdy_b;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_feat(input int n);
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < NF; k++) f[k*W +: W] = 32'hA000_0000 + 32'(n * NF + k);
    return f;
  endfunction

  // Monitors sample on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.node_vld_o && ifa.node_rdy_i)
        xqa.push_back('{ifa.node_feat_o, int'(ifa.node_idx_o), ifa.node_last_o, cyc});
      if (ifa.feat_bram_enb) begin
        rda.push_back(int'(ifa.feat_bram_addrb));
        rdc.push_back(cyc);
      end
      if (done_a) begin
        n_done_a++;
        done_cyc_a = cyc;
      end
      if (ifa.node_vld_o) check("hold_no_read", ifa.feat_bram_enb, 1'b0);
      if (ifb.node_vld_o && ifb.node_rdy_i)
        xqb.push_back('{ifb.node_feat_o, int'(ifb.node_idx_o), ifb.node_last_o, cyc});
      if (done_b) n_done_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    xqa.delete();
    rda.delete();
    rdc.delete();
    n_done_a = 0;
  endtask

  task automatic pulse_start_a(output int c0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int n;
    n = 0;
    while (busy_a && n < budget) begin
      tick();
      n++;
    end
    check(tag, busy_a, 1'b0);
  endtask

  task automatic check_quiet_a(input string tag);
    check({tag, "_vld"},   ifa.node_vld_o, 1'b0);
    check({tag, "_enb"},   ifa.feat_bram_enb, 1'b0);
    check({tag, "_addrb"}, ifa.feat_bram_addrb, '0);
    check({tag, "_feat"},  ifa.node_feat_o, '0);
    check({tag, "_idx"},   ifa.node_idx_o, '0);
    check({tag, "_last"},  ifa.node_last_o, 1'b0);
    check({tag, "_busy"},  busy_a, 1'b0);
    check({tag, "_done"},  done_a, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, nrd;
    exp_n[0] = 128'hA0000003_A0000002_A0000001_A0000000;
    exp_n[1] = 128'hA0000007_A0000006_A0000005_A0000004;
    exp_n[2] = 128'hA000000B_A000000A_A0000009_A0000008;

    // Reset with start held high: reset wins
    start_a = 1'b1;
    repeat (3) tick();
    check_quiet_a("rst");
    start_a = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1: free-running downstream, latency, period, packing, last and done
    rdy_a = 1'b1;
    clear_a();
    pulse_start_a(c0);
    wait_idle_a("t1_idle", 100);
    check("t1_nodes", xqa.size(), 3);
    if (xqa.size() == 3) begin
      for (int i = 0; i < NS; i++) begin
        check("t1_feat", xqa[i].feat, exp_n[i]);
        check("t1_idx", xqa[i].idx, i);
        check("t1_last", xqa[i].last, (i == NS - 1));
      end
      check("t1_first_vld_cyc", xqa[0].cyc - c0, 6);
      check("t1_period1", xqa[1].cyc - xqa[0].cyc, 7);
      check("t1_period2", xqa[2].cyc - xqa[1].cyc, 7);
    end
    check("t1_reads", rda.size(), 12);
    if (rda.size() == 12) begin
      for (int j = 0; j < 12; j++) check("t1_addr", rda[j], j);
      for (int j = 0; j < 4; j++) check("t1_rd_cyc", rdc[j] - c0, j);
    end
    check("t1_done_cnt", n_done_a, 1);
    check("t1_done_cyc", done_cyc_a - c0, 21);

    // 2: backpressure in node 1 HOLD
    clear_a();
    rdy_a = 1'b1;
    pulse_start_a(c0);
    n = 0;
    while (xqa.size() < 1 && n < 50) begin tick(); n++; end
    rdy_a = 1'b0;
    n = 0;
    while (!ifa.node_vld_o && n < 50) begin tick(); n++; end
    check("t2_vld_rise", ifa.node_vld_o, 1'b1);
    nrd = rda.size();
    check("t2_reads_before_stall", nrd, 8);
    for (int i = 0; i < 10; i++) begin
      check("t2_stall_vld", ifa.node_vld_o, 1'b1);
      check("t2_stall_feat", ifa.node_feat_o, exp_n[1]);
      check("t2_stall_idx", ifa.node_idx_o, 1);
      tick();
    end
    check("t2_no_reads_stalled", rda.size(), 8);
    rdy_a = 1'b1;
    wait_idle_a("t2_idle", 100);
    check("t2_nodes", xqa.size(), 3);
    if (xqa.size() == 3) begin
      check("t2_feat1", xqa[1].feat, exp_n[1]);
      check("t2_feat2", xqa[2].feat, exp_n[2]);
    end
    check("t2_reads", rda.size(), 12);
    if (rda.size() == 12)
      for (int j = 8; j < 12; j++) check("t2_node2_addr", rda[j], j);

    // 3: start held high for the whole run
    clear_a();
    start_a = 1'b1;
    tick();
    n = 0;
    while (n_done_a == 0 && n < 100) begin tick(); n++; end
    start_a = 1'b0;
    check("t3_done_cnt", n_done_a, 1);
    check("t3_nodes", xqa.size(), 3);
    check("t3_reads", rda.size(), 12);
    check("t3_busy_idle", busy_a, 1'b0);
    tick();
    check("t3_no_restart", busy_a, 1'b0);
    pulse_start_a(c0);
    check("t3_restart_busy", busy_a, 1'b1);
    wait_idle_a("t3_idle", 100);
    check("t3_nodes2", xqa.size(), 6);

    // 4: asynchronous reset during node 1 FETCH
    clear_a();
    pulse_start_a(c0);
    n = 0;
    while (rda.size() < 6 && n < 100) begin tick(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet_a("t4_async");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_a();
    pulse_start_a(c0);
    wait_idle_a("t4_idle", 100);
    check("t4_nodes", xqa.size(), 3);
    if (xqa.size() == 3) begin
      for (int i = 0; i < NS; i++) begin
        check("t4_feat", xqa[i].feat, exp_n[i]);
        check("t4_idx", xqa[i].idx, i);
      end
    end

    // 5: read latency 1 instance
    xqb.delete();
    n_done_b = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    c0 = cyc;
    n = 0;
    while (busy_b && n < 100) begin tick(); n++; end
    check("t5_idle", busy_b, 1'b0);
    check("t5_nodes", xqb.size(), 3);
    if (xqb.size() == 3) begin
      for (int i = 0; i < NS; i++) begin
        check("t5_feat", xqb[i].feat, exp_n[i]);
        check("t5_idx", xqb[i].idx, i);
      end
      check("t5_first_vld_cyc", xqb[0].cyc - c0, 5);
      check("t5_period1", xqb[1].cyc - xqb[0].cyc, 6);
      check("t5_period2", xqb[2].cyc - xqb[1].cyc, 6);
    end
    check("t5_done_cnt", n_done_b, 1);

    // 6: random ready over many runs
    for (int r = 0; r < 200; r++) begin
      clear_a();
      rdy_a = 1'($urandom_range(0, 1));
      pulse_start_a(c0);
      n = 0;
      while (busy_a && n < 300) begin
        rdy_a = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      check("t6_idle", busy_a, 1'b0);
      check("t6_nodes", xqa.size(), 3);
      check("t6_done_cnt", n_done_a, 1);
      for (int i = 0; i < xqa.size(); i++) begin
        check("t6_feat", xqa[i].feat, exp_feat(i));
        check("t6_idx", xqa[i].idx, i);
        check("t6_last", xqa[i].last, (i == NS - 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
